// File: rtl/pixel_pack_out.sv
// Packs a ready/valid 8-bit pixel stream into 32-bit words with start-of-frame / end-of-line flags.
// Optional per-frame min/max/sum statistics are enabled by defining STATS_EN.
module pixel_pack_out #(
  parameter int IMG_WIDTH  = 1024,
  parameter int IMG_HEIGHT = 1024,
  parameter int FCNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_pixel,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sync_clr,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_last,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic [7:0]        stat_min,
  output logic [7:0]        stat_max,
  output logic [31:0]       stat_sum,
  output logic              stat_valid
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [1:0]    lane;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [23:0]   pack;
  logic          accept;
  logic          load;
  logic          col_wrap;
  logic          frame_end;

  // Handshake: a pixel moves when in_valid && in_ready, a word moves when out_valid && out_ready.
  // Only the lane-3 pixel can stall, and only when the output word is full and not draining.
  assign in_ready  = !rst && !sync_clr && ((lane != 2'd3) || !out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign load      = accept && (lane == 2'd3);
  assign col_wrap  = (col == COL_LAST);
  assign frame_end = col_wrap && (row == ROW_LAST);

  always_ff @(posedge clk) begin
    if (rst || sync_clr) begin
      lane <= 2'd0;
      col  <= '0;
      row  <= '0;
      pack <= '0;
    end else if (accept) begin
      case (lane)
        2'd0:    pack[7:0]   <= in_pixel;
        2'd1:    pack[15:8]  <= in_pixel;
        2'd2:    pack[23:16] <= in_pixel;
        default: pack        <= pack;
      endcase
      lane <= lane + 2'd1;
      if (col_wrap) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Width is a multiple of 4, so lane 3 always lines up with col%4==3 and frame_end coincides with a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_last  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (load) begin
        out_data  <= {in_pixel, pack};
        out_valid <= 1'b1;
        out_sof   <= (row == '0) && (col == CW'(3));
        out_last  <= col_wrap;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && frame_end) begin
        frame_cnt <= frame_cnt + FCNT_W'(1);
      end
    end
  end

`ifdef STATS_EN
  logic [7:0]  run_min;
  logic [7:0]  run_max;
  logic [31:0] run_sum;
  logic [7:0]  nxt_min;
  logic [7:0]  nxt_max;
  logic [31:0] nxt_sum;
  logic        first_px;

  // Pixel (0,0) seeds the accumulators; sync_clr realigns position so the next frame reseeds.
  always_comb begin
    first_px = (col == '0) && (row == '0);
    nxt_min  = (first_px || (in_pixel < run_min)) ? in_pixel : run_min;
    nxt_max  = (first_px || (in_pixel > run_max)) ? in_pixel : run_max;
    nxt_sum  = first_px ? {24'd0, in_pixel} : run_sum + {24'd0, in_pixel};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_min    <= '0;
      run_max    <= '0;
      run_sum    <= '0;
      stat_min   <= '0;
      stat_max   <= '0;
      stat_sum   <= '0;
      stat_valid <= 1'b0;
    end else begin
      stat_valid <= 1'b0;
      if (sync_clr) begin
        run_min <= '0;
        run_max <= '0;
        run_sum <= '0;
      end else if (accept) begin
        run_min <= nxt_min;
        run_max <= nxt_max;
        run_sum <= nxt_sum;
        if (frame_end) begin
          stat_min   <= nxt_min;
          stat_max   <= nxt_max;
          stat_sum   <= nxt_sum;
          stat_valid <= 1'b1;
        end
      end
    end
  end
`else
  assign stat_min   = '0;
  assign stat_max   = '0;
  assign stat_sum   = '0;
  assign stat_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_pack_out.sv
// Directed bench for pixel_pack_out (8x2 image, 2-bit frame counter) with a frame-position
// reference model, a word scoreboard and literal checks of the expected word sequences.
module tb_pixel_pack_out;

  localparam int W  = 8;
  localparam int H  = 2;
  localparam int FW = 2;
`ifdef STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    in_pixel = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          sync_clr = 1'b0;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_sof;
  logic          out_last;
  logic [FW-1:0] frame_cnt;
  logic [7:0]    stat_min;
  logic [7:0]    stat_max;
  logic [31:0]   stat_sum;
  logic          stat_valid;

  pixel_pack_out #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .FCNT_W(FW)) dut (
    .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
    .sync_clr(sync_clr), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_last(out_last), .frame_cnt(frame_cnt), .stat_min(stat_min),
    .stat_max(stat_max), .stat_sum(stat_sum), .stat_valid(stat_valid)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit rdy_mode = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rdy_mode) out_ready = ~out_ready;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [33:0]   exp_q[$];     // {sof, last, data}
  logic [31:0]   got_d[$];
  logic [1:0]    got_f[$];     // {sof, last}
  int            pos = 0;
  int            grp_n = 0;
  logic [7:0]    grp_b[4];
  logic          grp_sof = 1'b0;
  logic [FW-1:0] exp_fcnt = '0;
  logic [7:0]    smin = '0, smax = '0, exp_smin = '0, exp_smax = '0;
  logic [31:0]   ssum = '0, exp_ssum = '0;
  logic          exp_sv = 1'b0;
  logic          hold_prev = 1'b0;
  logic [33:0]   prev_word = '0;
  int            stat_pulses = 0;

  always @(negedge clk) begin
    logic        exp_rdy;
    logic [33:0] w;
    exp_rdy = !rst && !sync_clr && !(grp_n == 3 && exp_q.size() != 0 && !out_ready);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, exp_q.size() != 0);
    chk("frame_cnt", frame_cnt, exp_fcnt);
    chk("stat_valid", stat_valid, STATS ? exp_sv : 1'b0);
    chk("stat_min", stat_min, STATS ? exp_smin : 8'd0);
    chk("stat_max", stat_max, STATS ? exp_smax : 8'd0);
    chk("stat_sum", stat_sum, STATS ? exp_ssum : 32'd0);
    if (hold_prev) chk("hold_word", {out_valid, out_sof, out_last, out_data}, {1'b1, prev_word});
    if (!rst && out_valid && out_ready && exp_q.size() != 0) begin
      w = exp_q.pop_front();
      chk("word_data", out_data, w[31:0]);
      chk("word_sof", out_sof, w[33]);
      chk("word_last", out_last, w[32]);
      got_d.push_back(out_data);
      got_f.push_back({out_sof, out_last});
    end
    hold_prev = !rst && out_valid && !out_ready;
    prev_word = {out_sof, out_last, out_data};
    if (stat_valid) stat_pulses++;
    exp_sv = 1'b0;
    if (rst) begin
      exp_q.delete();
      pos = 0; grp_n = 0; exp_fcnt = '0;
      exp_smin = '0; exp_smax = '0; exp_ssum = '0;
    end else if (sync_clr) begin
      pos = 0; grp_n = 0;
    end else if (in_valid && in_ready) begin
      if (grp_n == 0) grp_sof = (pos == 0);
      grp_b[grp_n] = in_pixel;
      if (pos == 0) begin
        smin = in_pixel; smax = in_pixel; ssum = 32'(in_pixel);
      end else begin
        if (in_pixel < smin) smin = in_pixel;
        if (in_pixel > smax) smax = in_pixel;
        ssum = ssum + 32'(in_pixel);
      end
      if (grp_n == 3) begin
        exp_q.push_back({grp_sof, (pos % W) == W - 1, grp_b[3], grp_b[2], grp_b[1], grp_b[0]});
        grp_n = 0;
      end else begin
        grp_n++;
      end
      if (pos == W * H - 1) begin
        pos = 0;
        exp_fcnt = exp_fcnt + 1'b1;
        exp_smin = smin; exp_smax = smax; exp_ssum = ssum; exp_sv = 1'b1;
      end else begin
        pos++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pixel(input logic [7:0] p);
    int n;
    n = 0;
    in_pixel = p;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout pixel=%0h never accepted", p);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d", exp_q.size());
    end
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    sync_clr = 1'b0;
    rdy_mode = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_flags", {out_sof, out_last}, 2'b00);
    chk("rst_frame_cnt", frame_cnt, '0);
    chk("rst_in_ready", in_ready, 1'b0);
    tick();
    rst = 1'b0;
    got_d.delete();
    got_f.delete();
    stat_pulses = 0;
  endtask

  // ---------------- directed tests ----------------
  logic [7:0] sp[16] = '{8'd5, 8'd200, 8'd17, 8'd0, 8'd10, 8'd20, 8'd30, 8'd40,
                         8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd100, 8'd110, 8'd9};
  logic [FW-1:0] fseq[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    // continuous stream of one frame
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) send_pixel(8'(i));
    wait_drain();
    chk("t1_count", got_d.size(), 4);
    chk("t1_w0", {got_f[0], got_d[0]}, {2'b10, 32'h03020100});
    chk("t1_w1", {got_f[1], got_d[1]}, {2'b01, 32'h07060504});
    chk("t1_w2", {got_f[2], got_d[2]}, {2'b00, 32'h0B0A0908});
    chk("t1_w3", {got_f[3], got_d[3]}, {2'b01, 32'h0F0E0D0C});
    chk("t1_fcnt", frame_cnt, 2'd1);

    // output back-pressure: lane 3 stalls on a full output register
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) send_pixel(8'(i));
    in_pixel = 8'd7;
    in_valid = 1'b1;
    tick(); tick(); tick();
    @(negedge clk);
    chk("t2_stall_ready", in_ready, 1'b0);
    chk("t2_hold_data", {out_valid, out_data}, {1'b1, 32'h03020100});
    tick();
    out_ready = 1'b1;
    send_pixel(8'd7);
    wait_drain();
    chk("t2_count", got_d.size(), 2);
    chk("t2_w0", got_d[0], 32'h03020100);
    chk("t2_w1", {got_f[1], got_d[1]}, {2'b01, 32'h07060504});

    // toggling out_ready over three frames
    do_reset();
    out_ready = 1'b0;
    rdy_mode = 1'b1;
    for (int i = 0; i < 48; i++) send_pixel(8'(i));
    wait_drain();
    rdy_mode = 1'b0;
    tick();
    out_ready = 1'b1;
    chk("t3_count", got_d.size(), 12);
    chk("t3_w4", {got_f[4], got_d[4]}, {2'b10, 32'h13121110});
    chk("t3_w11", {got_f[11], got_d[11]}, {2'b01, 32'h2F2E2D2C});
    chk("t3_fcnt", frame_cnt, 2'd3);

    // sync_clr drops a partial word and realigns the frame
    do_reset();
    send_pixel(8'hAA);
    send_pixel(8'hBB);
    in_pixel = 8'hCC;
    in_valid = 1'b1;
    sync_clr = 1'b1;
    @(negedge clk);
    chk("t4_sync_ready", in_ready, 1'b0);
    tick();
    sync_clr = 1'b0;
    in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) send_pixel(8'(i));
    wait_drain();
    chk("t4_count", got_d.size(), 1);
    chk("t4_w0", {got_f[0], got_d[0]}, {2'b10, 32'h04030201});

    // per-frame statistics
    do_reset();
    for (int i = 0; i < 16; i++) send_pixel(sp[i]);
    wait_drain();
    chk("t5_min", stat_min, STATS ? 8'd0 : 8'd0);
    chk("t5_max", stat_max, STATS ? 8'd200 : 8'd0);
    chk("t5_sum", stat_sum, STATS ? 32'd891 : 32'd0);
    chk("t5_pulses", stat_pulses, STATS ? 1 : 0);

    // frame counter wraps at 2 bits
    do_reset();
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 16; i++) send_pixel(8'(f * 16 + i));
      tick();
      chk("t6_fcnt", frame_cnt, fseq[f]);
    end
    wait_drain();

    // reset mid-frame drops the pending word
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_pixel(8'(i + 100));
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_pixel(8'(i));
    wait_drain();
    chk("t7_count", got_d.size(), 2);
    chk("t7_w0", {got_f[0], got_d[0]}, {2'b10, 32'h03020100});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pixel_pack_out.md
Name: pixel_pack_out

Overview:
- Output stage sitting directly downstream of the pixel processor, in the 100 MHz processing clock domain.
- Accepts the processor's 8-bit ready/valid pixel stream and packs 4 pixels into 32-bit words for the memory/DMA side.
- Tracks column/row position to mark start-of-frame and end-of-line, and counts completed frames.

Parameters:
- IMG_WIDTH, 1024, pixels per line; must be a multiple of 4.
- IMG_HEIGHT, 1024, lines per frame.
- FCNT_W, 16, width of frame counter.

Ports:
- clk  in  1  processing clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_pixel  in  8  pixel from processor
- in_valid  in  1  in_pixel valid
- in_ready  out  1  stage can accept pixel
- sync_clr  in  1  synchronous realign: drop partial word, restart frame position
- out_data  out  32  packed word; first pixel of group in [7:0], last in [31:24]
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts word
- out_sof  out  1  word holds pixel (0,0) of a frame
- out_last  out  1  word holds last pixel of a line
- frame_cnt  out  FCNT_W  completed frames, wraps modulo 2^FCNT_W
- stat_min, stat_max  out  8  per-frame min/max (STATS_EN only)
- stat_sum  out  32  per-frame pixel sum (STATS_EN only)
- stat_valid  out  1  one-cycle pulse, stats updated (STATS_EN only)

Behaviour:
- Reset: out_data=0, out_valid=0, out_sof=0, out_last=0, frame_cnt=0, lane=0, col=0, row=0, all stat outputs 0, stat_valid=0. in_ready is combinational and is 0 while rst=1.
- Pixel accept = in_valid && in_ready.
- in_ready = !rst && !sync_clr && ((lane != 3) || !out_valid || out_ready).
  - Lanes 0-2 never stall.
  - Lane 3 stalls only if the output register is full and not draining.
- Packing:
  - An accepted pixel writes byte [8*lane+7:8*lane] of the pack register; lane increments mod 4.
  - On lane 3 accept, the full word (pack bytes 0-2 plus the incoming pixel) loads out_data the next cycle with out_valid=1.
  - Latency from 4th pixel accept to out_valid is 1 cycle.
- Output register:
  - Holds while out_valid && !out_ready.
  - Clears out_valid after out_ready unless a new word loads the same cycle; simultaneous drain+load gives back-to-back words with no bubble.
- Position:
  - col increments per accepted pixel.
  - At col==IMG_WIDTH-1: col→0, row increments.
  - At row==IMG_HEIGHT-1 and col wrap: row→0, frame_cnt increments in the same cycle as the final word load.
- Flags: out_sof=1 for the word whose first pixel was at (col 0, row 0). out_last=1 for the word whose 4th pixel was at col IMG_WIDTH-1. Both latch with out_data.
- sync_clr (priority over pixel accept; in_ready forced 0):
  - Next cycle lane=col=row=0; partial pack discarded.
  - The output register and frame_cnt are unaffected; a pending word still drains normally.
- Stalls never lose or duplicate pixels. Data/flags stay stable while out_valid && !out_ready.
- rst mid-frame: everything returns to reset values next cycle; the pending word is dropped.

Optional Feature:
- STATS_EN defined:
  - Running min/max/sum update on every accepted pixel; the first pixel of a frame (col 0, row 0) seeds min/max/sum.
  - When the last pixel of a frame is accepted, stat_min/stat_max/stat_sum latch the final values (including that pixel) and stat_valid pulses 1 cycle.
  - sync_clr restarts accumulation without a pulse.
  - Sum cannot overflow at default sizes (max 267,386,880 < 2^32).
- STATS_EN undefined: stat_min, stat_max, stat_sum tie to 0; stat_valid ties to 0; no accumulator logic.

Test Plan (IMG_WIDTH=8, IMG_HEIGHT=2 unless noted):
- Reset released, out_ready=1, stream pixels 0..15 continuously → words 0x03020100 (sof=1, last=0), 0x07060504 (last=1), 0x0B0A0908 (sof=0), 0x0F0E0D0C (last=1); frame_cnt=1 after final word.
- out_ready=0 while pixels 0..7 are offered → first word holds at 0x03020100; in_ready drops on the 8th pixel (lane 3, output full); raising out_ready delivers 0x07060504 next with no loss.
- Toggle out_ready every cycle over 3 frames of pixel value = index mod 256 → word sequence exact and gap-free; frame_cnt=3.
- Accept pixels 0xAA, 0xBB, then pulse sync_clr with in_valid=1 → in_ready=0 that cycle; the next 4 pixels 1,2,3,4 emit 0x04030201 with out_sof=1.
- STATS_EN, frame of pixels {5,200,17,0,...,9} → stat_min=0, stat_max=200, stat_sum equals the exact total; stat_valid is a single pulse, aligned the cycle after the last pixel accept.
- FCNT_W=2, run 5 frames → frame_cnt sequence 1,2,3,0,1.
